// File: rtl/vec_lsu_sequencer.sv
`timescale 1ns/1ps
// Vector load/store sequencer: walks one vector memory instruction element by
// element over a single-ported scalar memory and writes loaded elements back.
module vec_lsu_sequencer #(
    parameter int XLEN   = 32,
    parameter int MAX_VL = 64,
    parameter int IDX_W  = $clog2(MAX_VL) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ld_inst,
    input  logic             st_inst,
    input  logic             stride_sel,
    input  logic             index_str,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [1:0]       sew,
    input  logic [IDX_W-1:0] vl,
    input  logic [XLEN-1:0]  idx_offset,
    input  logic [XLEN-1:0]  st_data,
    output logic [IDX_W-1:0] elem_idx,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_addr,
    output logic             mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic             mem_rsp_valid,
    input  logic [XLEN-1:0]  mem_rsp_data,
    output logic             elem_wr_en,
    output logic [IDX_W-1:0] elem_wr_idx,
    output logic [XLEN-1:0]  elem_wr_data,
    output logic             busy,
    output logic             done
);

    localparam int BW    = XLEN / 8;
    localparam int LOW_W = $clog2(BW);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, DONE} state_t;

    state_t           state_q;
    logic [XLEN-1:0]  base_q;
    logic [XLEN-1:0]  stride_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  rdata_q;
    logic [1:0]       sew_q;
    logic [IDX_W-1:0] vl_q;
    logic [IDX_W-1:0] elemIdx_q;
    logic             isLoad_q;
    logic             unit_q;
    logic             indexed_q;
    logic [LOW_W-1:0] low_q;

    logic [XLEN-1:0]  curAddr;
    logic [LOW_W-1:0] curLow;
    logic [XLEN-1:0]  incr;
    logic [XLEN-1:0]  addr_d;
    logic [IDX_W-1:0] elemIdx_d;
    logic             lastElem;
    logic             opValid;
    logic [1:0]       sewIn;
    logic [BW-1:0]    beBase;
    logic [XLEN-1:0]  sewMask;

    // Strided modes advance a running address; indexed mode adds the offset live in REQ.
    always_comb begin
        sewIn     = (sew == 2'b11) ? 2'b10 : sew;
        curAddr   = indexed_q ? (base_q + idx_offset) : addr_q;
        curLow    = curAddr[LOW_W-1:0];
        incr      = unit_q ? (XLEN'(1) << sew_q) : stride_q;
        addr_d    = addr_q + incr;
        elemIdx_d = elemIdx_q + IDX_W'(1);
        lastElem  = (elemIdx_d == vl_q);
        opValid   = start & (ld_inst ^ st_inst);
        case (sew_q)
            2'd0: begin
                beBase  = BW'(4'h1);
                sewMask = XLEN'(32'h0000_00FF);
            end
            2'd1: begin
                beBase  = BW'(4'h3);
                sewMask = XLEN'(32'h0000_FFFF);
            end
            default: begin
                beBase  = BW'(4'hF);
                sewMask = XLEN'(32'hFFFF_FFFF);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            stride_q  <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
            sew_q     <= '0;
            vl_q      <= '0;
            elemIdx_q <= '0;
            isLoad_q  <= 1'b0;
            unit_q    <= 1'b0;
            indexed_q <= 1'b0;
            low_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (opValid) begin
                        base_q    <= rs1_data;
                        stride_q  <= rs2_data;
                        addr_q    <= rs1_data;
                        sew_q     <= sewIn;
                        vl_q      <= vl;
                        isLoad_q  <= ld_inst;
                        unit_q    <= stride_sel;
                        indexed_q <= index_str;
                        elemIdx_q <= '0;
                        state_q   <= (vl == '0) ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        low_q <= curLow;
                        if (isLoad_q) begin
                            state_q <= WAIT;
                        end else begin
                            elemIdx_q <= elemIdx_d;
                            addr_q    <= addr_d;
                            state_q   <= lastElem ? DONE : REQ;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        rdata_q <= (mem_rsp_data >> {low_q, 3'b000}) & sewMask;
                        state_q <= WB;
                    end
                end
                WB: begin
                    elemIdx_q <= elemIdx_d;
                    addr_q    <= addr_d;
                    state_q   <= lastElem ? DONE : REQ;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory-side fields are forced to zero outside REQ so idle outputs stay quiet.
    assign elem_idx      = elemIdx_q;
    assign mem_req_valid = (state_q == REQ);
    assign mem_we        = mem_req_valid & ~isLoad_q;
    assign mem_addr      = mem_req_valid ? curAddr : '0;
    assign mem_be        = mem_req_valid ? (beBase << curLow) : '0;
    assign mem_wdata     = mem_req_valid ? (st_data << {curLow, 3'b000}) : '0;
    assign elem_wr_en    = (state_q == WB);
    assign elem_wr_idx   = elem_wr_en ? elemIdx_q : '0;
    assign elem_wr_data  = elem_wr_en ? rdata_q : '0;
    assign busy          = (state_q == REQ) || (state_q == WAIT) || (state_q == WB);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_vec_lsu_sequencer.sv
`timescale 1ns/1ps
// Bench for vec_lsu_sequencer: an element-list model of each instruction is
// compared against every memory request, writeback and done pulse.
module tb_vec_lsu_sequencer;

    localparam int XLEN  = 32;
    localparam int IDX_W = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             ld_inst;
    logic             st_inst;
    logic             stride_sel;
    logic             index_str;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [1:0]       sew;
    logic [IDX_W-1:0] vl;
    logic [XLEN-1:0]  idx_offset;
    logic [XLEN-1:0]  st_data;
    logic [IDX_W-1:0] elem_idx;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [XLEN-1:0]  mem_addr;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [XLEN-1:0]  mem_wdata;
    logic             mem_rsp_valid;
    logic [XLEN-1:0]  mem_rsp_data;
    logic             elem_wr_en;
    logic [IDX_W-1:0] elem_wr_idx;
    logic [XLEN-1:0]  elem_wr_data;
    logic             busy;
    logic             done;

    vec_lsu_sequencer #(.XLEN(32), .MAX_VL(64), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .start(start), .ld_inst(ld_inst), .st_inst(st_inst),
        .stride_sel(stride_sel), .index_str(index_str), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .sew(sew), .vl(vl), .idx_offset(idx_offset),
        .st_data(st_data), .elem_idx(elem_idx), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .elem_wr_en(elem_wr_en), .elem_wr_idx(elem_wr_idx),
        .elem_wr_data(elem_wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Register-file side: offsets and store data looked up by the current element.
    logic [31:0] offsTab [0:127];
    logic [31:0] stTab   [0:127];
    assign idx_offset = offsTab[elem_idx];
    assign st_data    = stTab[elem_idx];

    bit          constRspEn;
    logic [31:0] constRsp;

    // Expected element lists, appended per instruction and consumed by the checker.
    logic [31:0] eAddr   [0:1023];
    logic [6:0]  eElem   [0:1023];
    logic [3:0]  eBe     [0:1023];
    logic        eWe     [0:1023];
    logic [31:0] eWdata  [0:1023];
    logic [6:0]  eWrIdx  [0:1023];
    logic [31:0] eWrData [0:1023];
    int expReqN, expWrN, expDoneN;
    int reqPos, wrPos, donePos;

    int nCmp, nFail;

    bit bpEn;
    int doneCyc, nSeen, nWr, seenStalls;
    logic [6:0]  seenStallIdx;
    logic [31:0] seenAddr [0:15];
    logic [3:0]  seenBe   [0:15];
    logic [31:0] seenWd   [0:15];
    logic [31:0] seenWr   [0:15];

    function automatic logic [31:0] memRead(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (constRspEn) return constRsp;
        return {w[15:0] ^ 16'hA5C3, w[15:0] + 16'h1111};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic buildModel(input bit ld, input bit unit, input bit idxm,
                              input logic [31:0] base, input logic [31:0] stride,
                              input logic [1:0] sw, input int n);
        int sb, nb;
        logic [31:0] a, mask;
        logic [1:0] low;
        sb   = (sw == 2'b11) ? 2 : int'(sw);
        nb   = 1 << sb;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        for (int i = 0; i < n; i++) begin
            if (idxm)      a = base + offsTab[i];
            else if (unit) a = base + (32'(i) << sb);
            else           a = base + 32'(i) * stride;
            low = a[1:0];
            eAddr[expReqN]  = a;
            eElem[expReqN]  = 7'(i);
            eBe[expReqN]    = 4'(((1 << nb) - 1) << low);
            eWe[expReqN]    = !ld;
            eWdata[expReqN] = stTab[i] << (8 * low);
            expReqN++;
            if (ld) begin
                eWrIdx[expWrN]  = 7'(i);
                eWrData[expWrN] = (memRead(a) >> (8 * low)) & mask;
                expWrN++;
            end
        end
        expDoneN++;
    endtask

    task automatic applyStimulus(input bit ld, input bit st, input bit unit, input bit idxm,
                                 input logic [31:0] base, input logic [31:0] stride,
                                 input logic [1:0] sw, input int n);
        @(posedge clk); #1;
        start = 1'b1; ld_inst = ld; st_inst = st; stride_sel = unit; index_str = idxm;
        rs1_data = base; rs2_data = stride; sew = sw; vl = 7'(n);
        @(posedge clk); #1;
        start = 1'b0; ld_inst = 1'b0; st_inst = 1'b0;
    endtask

    // Called one cycle after start; records what the DUT does until done.
    task automatic waitDone();
        doneCyc = 1; nSeen = 0; nWr = 0; seenStalls = 0; seenStallIdx = '0;
        #1;
        forever begin
            if (mem_req_valid && mem_req_ready && nSeen < 16) begin
                seenAddr[nSeen] = mem_addr; seenBe[nSeen] = mem_be; seenWd[nSeen] = mem_wdata;
                nSeen++;
            end
            if (mem_req_valid && !mem_req_ready) begin
                seenStalls++;
                seenStallIdx = elem_idx;
            end
            if (elem_wr_en && nWr < 16) begin
                seenWr[nWr] = elem_wr_data;
                nWr++;
            end
            if (done) break;
            if (doneCyc >= 300) begin
                checkOutput("done timeout", {63'd0, done}, 64'd1);
                break;
            end
            @(posedge clk); #2;
            doneCyc++;
        end
    endtask

    task automatic endCheck();
        @(negedge clk); #1;
        checkOutput("requests consumed", reqPos, expReqN);
        checkOutput("writes consumed", wrPos, expWrN);
        checkOutput("done consumed", donePos, expDoneN);
    endtask

    task automatic runOp(input bit ld, input bit st, input bit unit, input bit idxm,
                         input logic [31:0] base, input logic [31:0] stride,
                         input logic [1:0] sw, input int n);
        buildModel(ld, unit, idxm, base, stride, sw, n);
        applyStimulus(ld, st, unit, idxm, base, stride, sw, n);
        waitDone();
        endCheck();
    endtask

    // Compare process: every request, writeback and done is matched against the model.
    task automatic checkerLoop();
        forever begin
            @(negedge clk);
            if (reset) begin
                reqPos = expReqN; wrPos = expWrN; donePos = expDoneN;
            end else begin
                if (mem_req_valid) begin
                    checkOutput("request expected", {63'd0, reqPos < expReqN}, 64'd1);
                    if (reqPos < expReqN) begin
                        checkOutput("req addr", mem_addr, eAddr[reqPos]);
                        checkOutput("req elem_idx", elem_idx, eElem[reqPos]);
                        checkOutput("req be", mem_be, eBe[reqPos]);
                        checkOutput("req we", mem_we, eWe[reqPos]);
                        if (eWe[reqPos]) checkOutput("req wdata", mem_wdata, eWdata[reqPos]);
                        checkOutput("busy in req", busy, 1);
                        if (mem_req_ready) reqPos++;
                    end
                end
                if (elem_wr_en) begin
                    checkOutput("write expected", {63'd0, wrPos < expWrN}, 64'd1);
                    if (wrPos < expWrN) begin
                        checkOutput("wr idx", elem_wr_idx, eWrIdx[wrPos]);
                        checkOutput("wr data", elem_wr_data, eWrData[wrPos]);
                        wrPos++;
                    end
                end
                if (done) begin
                    checkOutput("done expected", {63'd0, donePos < expDoneN}, 64'd1);
                    checkOutput("busy at done", busy, 0);
                    if (donePos < expDoneN) donePos++;
                end
            end
        end
    endtask

    // Memory: answers each load handshake one cycle later, garbage otherwise.
    initial begin
        logic hs;
        logic [31:0] a;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs = mem_req_valid && mem_req_ready && !mem_we && !reset;
            a  = mem_addr;
            @(posedge clk); #1;
            mem_rsp_valid = hs;
            mem_rsp_data  = hs ? memRead(a) : 32'hDEAD_BEEF;
        end
    end

    // Ready: optionally stalls element 1 for three cycles.
    initial begin
        int stallCnt;
        stallCnt = 0;
        mem_req_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!bpEn) stallCnt = 0;
            if (bpEn && mem_req_valid && elem_idx == 7'd1 && stallCnt < 3) begin
                mem_req_ready = 1'b0;
                stallCnt++;
            end else begin
                mem_req_ready = 1'b1;
            end
        end
    end

    initial begin
        nCmp = 0; nFail = 0;
        expReqN = 0; expWrN = 0; expDoneN = 0;
        reqPos = 0; wrPos = 0; donePos = 0;
        bpEn = 0; constRspEn = 0; constRsp = '0;
        reset = 1'b1; start = 1'b0; ld_inst = 1'b0; st_inst = 1'b0;
        stride_sel = 1'b0; index_str = 1'b0; rs1_data = '0; rs2_data = '0;
        sew = '0; vl = '0;
        for (int i = 0; i < 128; i++) begin
            offsTab[i] = '0;
            stTab[i]   = '0;
        end
        fork
            checkerLoop();
        join_none

        #12;
        checkOutput("reset valid", mem_req_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset elem_idx", elem_idx, 0);
        checkOutput("reset addr", mem_addr, 0);
        checkOutput("reset be", mem_be, 0);
        checkOutput("reset wr_data", elem_wr_data, 0);
        #5 reset = 1'b0;

        $display("[TB] unit-stride load with a start while busy");
        buildModel(1, 1, 0, 32'h1000, 32'h0, 2'b10, 4);
        checkOutput("model addr3", eAddr[3], 32'h100C);
        checkOutput("model be0", eBe[0], 4'b1111);
        applyStimulus(1, 0, 1, 0, 32'h1000, 32'h0, 2'b10, 4);
        fork
            waitDone();
            begin
                @(posedge clk); #1;
                start = 1'b1; st_inst = 1'b1; rs1_data = 32'hFFFF_0000;
                rs2_data = 32'h8; sew = 2'b00; vl = 7'd5; stride_sel = 1'b0;
                @(posedge clk); #1;
                start = 1'b0; st_inst = 1'b0;
            end
        join
        endCheck();
        checkOutput("unit load done cycle", doneCyc, 13);
        checkOutput("unit load addr1", seenAddr[1], 32'h1004);
        checkOutput("unit load addr3", seenAddr[3], 32'h100C);
        checkOutput("unit load writes", nWr, 4);

        $display("[TB] strided byte store");
        for (int i = 0; i < 3; i++) stTab[i] = 32'hAB;
        buildModel(0, 0, 0, 32'h2003, 32'h10, 2'b00, 3);
        checkOutput("model wdata0", eWdata[expReqN-3], 32'hAB00_0000);
        applyStimulus(0, 1, 0, 0, 32'h2003, 32'h10, 2'b00, 3);
        waitDone();
        endCheck();
        checkOutput("store done cycle", doneCyc, 4);
        checkOutput("store addr2", seenAddr[2], 32'h2023);
        checkOutput("store be0", seenBe[0], 4'b1000);
        checkOutput("store wdata1", seenWd[1], 32'hAB00_0000);
        checkOutput("store writes", nWr, 0);

        $display("[TB] indexed halfword load");
        offsTab[0] = 32'd6; offsTab[1] = 32'd0; offsTab[2] = 32'd2;
        constRspEn = 1; constRsp = 32'h1234_5678;
        runOp(1, 0, 0, 1, 32'h3000, 32'h0, 2'b01, 3);
        checkOutput("indexed done cycle", doneCyc, 10);
        checkOutput("indexed addr0", seenAddr[0], 32'h3006);
        checkOutput("indexed be1", seenBe[1], 4'b0011);
        checkOutput("indexed be2", seenBe[2], 4'b1100);
        checkOutput("indexed data0", seenWr[0], 32'h1234);
        checkOutput("indexed data1", seenWr[1], 32'h5678);
        checkOutput("indexed data2", seenWr[2], 32'h1234);
        constRspEn = 0;
        for (int i = 0; i < 3; i++) offsTab[i] = '0;

        $display("[TB] backpressure on element 1");
        bpEn = 1;
        runOp(1, 0, 1, 0, 32'h4000, 32'h0, 2'b10, 3);
        bpEn = 0;
        checkOutput("bp stall cycles", seenStalls, 3);
        checkOutput("bp stall elem", seenStallIdx, 1);
        checkOutput("bp done cycle", doneCyc, 13);

        $display("[TB] reserved sew store and vl=0");
        stTab[0] = 32'h1122_3344; stTab[1] = 32'h5566_7788;
        runOp(0, 1, 1, 0, 32'h5000, 32'h0, 2'b11, 2);
        checkOutput("sew3 addr1", seenAddr[1], 32'h5004);
        checkOutput("sew3 be0", seenBe[0], 4'b1111);
        checkOutput("sew3 done cycle", doneCyc, 3);
        runOp(1, 0, 1, 0, 32'h5000, 32'h0, 2'b10, 0);
        checkOutput("vl0 done cycle", doneCyc, 1);
        checkOutput("vl0 requests", nSeen, 0);

        $display("[TB] malformed starts");
        applyStimulus(1, 1, 1, 0, 32'h8000, 32'h0, 2'b10, 2);
        repeat (3) @(posedge clk);
        #2 checkOutput("both ignored busy", busy, 0);
        applyStimulus(0, 0, 1, 0, 32'h8000, 32'h0, 2'b10, 2);
        repeat (3) @(posedge clk);
        #2 checkOutput("neither ignored busy", busy, 0);

        $display("[TB] reset during element 2 wait");
        buildModel(1, 1, 0, 32'h6000, 32'h0, 2'b10, 4);
        applyStimulus(1, 0, 1, 0, 32'h6000, 32'h0, 2'b10, 4);
        repeat (7) @(posedge clk);
        #2;
        checkOutput("pre-reset busy", busy, 1);
        checkOutput("pre-reset elem_idx", elem_idx, 2);
        checkOutput("pre-reset valid", mem_req_valid, 0);
        #1 reset = 1'b1;
        #1;
        checkOutput("async valid", mem_req_valid, 0);
        checkOutput("async busy", busy, 0);
        checkOutput("async elem_idx", elem_idx, 0);
        checkOutput("async addr", mem_addr, 0);
        checkOutput("async be", mem_be, 0);
        checkOutput("async wr_en", elem_wr_en, 0);
        checkOutput("async done", done, 0);
        @(posedge clk); #2 reset = 1'b0;
        repeat (5) @(posedge clk);
        #2 checkOutput("post-reset busy", busy, 0);
        runOp(1, 0, 1, 0, 32'h7000, 32'h0, 2'b10, 2);
        checkOutput("rerun done cycle", doneCyc, 7);
        checkOutput("rerun addr0", seenAddr[0], 32'h7000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/vec_lsu_sequencer.md
Name: vec_lsu_sequencer

Overview:
Sequences one vector load or store element-by-element against a single-ported scalar memory interface. Sits between the vector controller/decode stage (ld_inst, st_inst, stride_sel, index_str, base, stride, vl, sew) and the data memory. Generates per-element addresses for unit-stride, constant-stride and indexed modes. Writes load results back to the vector register file one element at a time, and signals completion to the issue logic.

Parameters:
XLEN, 32, address/data width of the memory port (byte lanes = XLEN/8 = 4)
MAX_VL, 64, maximum element count per instruction
IDX_W, $clog2(MAX_VL)+1, width of vl and element index

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  issue pulse; sampled only in IDLE
ld_inst  in  1  load instruction
st_inst  in  1  store instruction
stride_sel  in  1  1 = unit stride, 0 = constant stride (ignored when index_str=1)
index_str  in  1  indexed addressing
rs1_data  in  XLEN  base address
rs2_data  in  XLEN  byte stride (constant-stride mode)
sew  in  2  element width: 00=8b, 01=16b, 10=32b; 11 is reserved and treated as 32b
vl  in  IDX_W  element count
idx_offset  in  XLEN  byte offset for element elem_idx (indexed mode), from register file
st_data  in  XLEN  store element elem_idx, right-justified
elem_idx  out  IDX_W  current element index
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  XLEN  byte address
mem_we  out  1  1 = write
mem_be  out  XLEN/8  byte enables
mem_wdata  out  XLEN  lane-aligned write data
mem_rsp_valid  in  1  load data valid
mem_rsp_data  in  XLEN  load word
elem_wr_en  out  1  register-file element write
elem_wr_idx  out  IDX_W  element written
elem_wr_data  out  XLEN  zero-extended load element
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- FSM states: IDLE, REQ, WAIT, WB, DONE.
- Reset: state=IDLE. All outputs 0, including elem_idx, mem_addr, mem_be and elem_wr_data. Takes effect asynchronously mid-operation: mem_req_valid drops immediately and no write or done is produced.
- IDLE:
  - start=1 with exactly one of ld_inst/st_inst set: latch base, stride, sew, vl, mode and direction. Clear elem_idx. Go to REQ, or to DONE if vl=0.
  - start with neither or both of ld_inst/st_inst set: ignored.
  - start outside IDLE: ignored; latched operands are unchanged.
- Address for element i, modulo 2^XLEN:
  - unit stride: base + i<<sew
  - constant stride: base + i*stride, kept as a running accumulator, no multiplier
  - indexed: base + idx_offset, with idx_offset sampled while in REQ
- REQ:
  - mem_req_valid=1; mem_we = store; mem_be = ((1<<(1<<sew))-1) << addr[1:0].
  - mem_wdata = st_data << (8*addr[1:0]).
  - mem_addr, mem_be, mem_wdata and mem_we are held stable until mem_req_ready.
  - On handshake: a load goes to WAIT. A store increments elem_idx, then goes to REQ, or to DONE if elem_idx+1 == vl.
- WAIT: mem_req_valid=0. On mem_rsp_valid, register (mem_rsp_data >> 8*addr[1:0]) masked to SEW and go to WB. mem_rsp_valid outside WAIT is ignored.
- WB:
  - elem_wr_en=1 for exactly one cycle, with elem_wr_idx = elem_idx and elem_wr_data = registered element.
  - Then increment elem_idx and go to REQ, or to DONE if it was the last element.
- DONE: done=1 for one cycle, busy=0, then IDLE. busy=1 in REQ, WAIT and WB only.
- Latency: start in cycle 0 gives the first mem_req_valid in cycle 1. With zero-wait memory (ready=1, response one cycle after the handshake), a load element takes 3 cycles and a store element takes 1 cycle.
- Alignment: at most one outstanding request. Accesses must be naturally aligned; misaligned accesses are out of scope and not driven by the bench.

Test Plan:
- Unit-stride load: vl=4, sew=10, base=0x1000, ready=1 -> addresses 0x1000/4/8/C, be=1111. Writes idx 0..3 with the response data. done at cycle 13.
- Strided store: sew=00, base=0x2003, stride=0x10, vl=3, st_data=0xAB -> addresses 0x2003/0x2013/0x2023, be=1000, wdata=0xAB000000, mem_we=1. No elem_wr_en.
- Indexed load: sew=01, base=0x3000, offsets {6,0,2}, rsp_data=0x12345678 -> addresses 0x3006/0x3000/0x3002. be=1100/0011/1100. elem_wr_data=0x1234/0x5678/0x1234.
- Backpressure: mem_req_ready low for 3 cycles on element 1 -> mem_addr/mem_be held constant, elem_idx stays 1, then the sequence resumes.
- vl=0 with start -> no mem_req_valid, done pulses in cycle 1. A start while busy changes nothing.
- Reset in WAIT of element 2 -> outputs 0 immediately, no elem_wr_en or done. A new start afterwards runs from element 0.
